// File: rtl/kv_cache_pkg.sv
// kv_cache_pkg: shared types and helpers for kv_writeback_cache.
//   kv_cache_state_e : controller states
//   kv_off_w/kv_sets/kv_idx_w/kv_tag_w/kv_way_w : geometry derived from parameters
//   kv_merge_byte    : one byte lane of a strobed store merge
package kv_cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_EVICT,
      ST_FETCH_REQ,
      ST_FETCH_WAIT,
      ST_RESP
   } kv_cache_state_e;

   function automatic int kv_off_w(input int line_size);
      return $clog2(line_size);
   endfunction

   function automatic int kv_sets(input int line_num, input int way_num);
      return line_num / way_num;
   endfunction

   function automatic int kv_idx_w(input int line_num, input int way_num);
      return $clog2(line_num / way_num);
   endfunction

   function automatic int kv_tag_w(input int addr_w, input int line_size,
                                   input int line_num, input int way_num);
      return addr_w - kv_off_w(line_size) - kv_idx_w(line_num, way_num);
   endfunction

   // A direct-mapped cache still needs a 1-bit way/pointer field.
   function automatic int kv_way_w(input int way_num);
      return (way_num > 1) ? $clog2(way_num) : 1;
   endfunction

   function automatic logic [7:0] kv_merge_byte(input logic [7:0] i_old,
                                                input logic [7:0] i_new,
                                                input logic       i_en);
      return i_en ? i_new : i_old;
   endfunction

endpackage

// File: rtl/kv_writeback_cache_victim.sv
// kv_victim_select: combinational replacement choice for one set.
//   i_valid  : valid bit per way
//   i_rr     : round-robin pointer of the set
//   o_victim : one-hot way to replace
//   o_adv    : 1 when the pointer was consumed (set full) and must advance
module kv_victim_select
   import kv_cache_pkg::*;
#(
   parameter  int WAY_NUM = 4,
   localparam int WAY_W   = kv_way_w(WAY_NUM)
) (
   input  logic [WAY_NUM-1:0] i_valid,
   input  logic [WAY_W-1:0]   i_rr,
   output logic [WAY_NUM-1:0] o_victim,
   output logic               o_adv
);

   logic w_found;

   always_comb begin
      o_victim = '0;
      o_adv    = 1'b0;
      w_found  = 1'b0;
      // Lowest-numbered invalid way wins.
      for (int w = 0; w < WAY_NUM; w++) begin
         if (!i_valid[w] && !w_found) begin
            o_victim[w] = 1'b1;
            w_found     = 1'b1;
         end
      end
      if (!w_found) begin
         o_victim[i_rr] = 1'b1;
         o_adv          = 1'b1;
      end
   end

endmodule

// File: rtl/kv_writeback_cache.sv
// kv_writeback_cache: blocking N-way set-associative write-back, write-allocate cache.
//   i_req_*   : word load/store requests from the core (valid/ready)
//   o_rsp_*   : load data or post-merge store word (valid/ready)
//   o_fetch_* / i_fetch_* : line refill request and returned line
//   o_write_* / i_write_ready : dirty victim writeback
module kv_writeback_cache
   import kv_cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int WAY_NUM    = 4,
   parameter int LINE_SIZE  = 4,
   parameter int LINE_NUM   = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic [ADDR_WIDTH-1:0]   o_fetch_addr,
   output logic                    o_fetch_valid,
   input  logic                    i_fetch_ready,
   input  logic [DATA_WIDTH-1:0]   i_fetch_data [LINE_SIZE],
   input  logic                    i_fetch_valid,
   output logic                    o_fetch_ready,
   output logic [DATA_WIDTH-1:0]   o_write_data [LINE_SIZE],
   output logic [ADDR_WIDTH-1:0]   o_write_addr,
   output logic                    o_write_valid,
   input  logic                    i_write_ready
);

   localparam int OFF_W  = kv_off_w(LINE_SIZE);
   localparam int SETS   = kv_sets(LINE_NUM, WAY_NUM);
   localparam int IDX_W  = kv_idx_w(LINE_NUM, WAY_NUM);
   localparam int TAG_W  = kv_tag_w(ADDR_WIDTH, LINE_SIZE, LINE_NUM, WAY_NUM);
   localparam int WAY_W  = kv_way_w(WAY_NUM);
   localparam int STRB_W = DATA_WIDTH / 8;

   kv_cache_state_e r_state, w_state_nxt;

   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic [WAY_W-1:0]      r_way;      // hit way or chosen victim of the current request
   logic [DATA_WIDTH-1:0] r_rsp_data;

   logic [SETS-1:0][WAY_NUM-1:0] r_valid, r_dirty;
   logic [SETS-1:0][WAY_W-1:0]   r_rr;
   logic [TAG_W-1:0]             r_tag  [SETS][WAY_NUM];
   logic [DATA_WIDTH-1:0]        r_data [SETS][WAY_NUM][LINE_SIZE];

   // Address split of the registered request.
   logic [OFF_W-1:0] w_off;
   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   assign w_off = r_addr[OFF_W-1:0];
   assign w_idx = r_addr[OFF_W +: IDX_W];
   assign w_tag = r_addr[ADDR_WIDTH-1 -: TAG_W];

   logic [WAY_NUM-1:0] w_hit_vec;
   logic [WAY_W-1:0]   w_hit_way;
   logic               w_hit;

   always_comb begin
      w_hit_vec = '0;
      w_hit_way = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
         if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      end
   end
   assign w_hit = |w_hit_vec;

   logic [WAY_NUM-1:0] w_vic_oh;
   logic               w_rr_adv;
   logic [WAY_W-1:0]   w_vic_way, w_rr_nxt;
   logic               w_vic_dirty;

   kv_victim_select #(.WAY_NUM(WAY_NUM)) u_vsel (
      .i_valid  (r_valid[w_idx]),
      .i_rr     (r_rr[w_idx]),
      .o_victim (w_vic_oh),
      .o_adv    (w_rr_adv)
   );

   always_comb begin
      w_vic_way = '0;
      for (int w = 0; w < WAY_NUM; w++)
         if (w_vic_oh[w]) w_vic_way = WAY_W'(w);
   end

   assign w_rr_nxt    = (r_rr[w_idx] == WAY_W'(WAY_NUM - 1)) ? '0 : r_rr[w_idx] + 1'b1;
   assign w_vic_dirty = r_valid[w_idx][w_vic_way] & r_dirty[w_idx][w_vic_way];

   // The word being read/merged comes from the array on a hit and from the
   // returning refill line otherwise.
   logic [DATA_WIDTH-1:0] w_src_word, w_merged, w_rsp_word;
   assign w_src_word = (r_state == ST_LOOKUP) ? r_data[w_idx][w_hit_way][w_off]
                                              : i_fetch_data[w_off];
   always_comb begin
      w_merged = '0;
      for (int b = 0; b < STRB_W; b++)
         w_merged[b*8 +: 8] = kv_merge_byte(w_src_word[b*8 +: 8], r_wdata[b*8 +: 8], r_wstrb[b]);
   end
   assign w_rsp_word = r_we ? w_merged : w_src_word;

   // Next state and handshake outputs.
   always_comb begin
      w_state_nxt   = r_state;
      o_req_ready   = 1'b0;
      o_write_valid = 1'b0;
      o_fetch_valid = 1'b0;
      o_fetch_ready = 1'b0;
      o_rsp_valid   = 1'b0;
      o_write_addr  = '0;
      o_fetch_addr  = '0;
      for (int k = 0; k < LINE_SIZE; k++) o_write_data[k] = '0;
      case (r_state)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (w_hit)            w_state_nxt = ST_RESP;
            else if (w_vic_dirty) w_state_nxt = ST_EVICT;
            else                  w_state_nxt = ST_FETCH_REQ;
         end
         ST_EVICT: begin
            o_write_valid = 1'b1;
            o_write_addr  = {r_tag[w_idx][r_way], w_idx, {OFF_W{1'b0}}};
            for (int k = 0; k < LINE_SIZE; k++) o_write_data[k] = r_data[w_idx][r_way][k];
            if (i_write_ready) w_state_nxt = ST_FETCH_REQ;
         end
         ST_FETCH_REQ: begin
            o_fetch_valid = 1'b1;
            o_fetch_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
            if (i_fetch_ready) w_state_nxt = ST_FETCH_WAIT;
         end
         ST_FETCH_WAIT: begin
            o_fetch_ready = 1'b1;
            if (i_fetch_valid) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_rsp_data = r_rsp_data;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= ST_IDLE;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_way      <= '0;
         r_rsp_data <= '0;
         r_valid    <= '0;
         r_dirty    <= '0;
         r_rr       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_wstrb <= i_req_wstrb;
         end
         if (r_state == ST_LOOKUP) begin
            if (w_hit) begin
               r_way      <= w_hit_way;
               r_rsp_data <= w_rsp_word;
               if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            end else begin
               r_way <= w_vic_way;
               if (w_rr_adv) r_rr[w_idx] <= w_rr_nxt;
            end
         end
         if (r_state == ST_FETCH_WAIT && i_fetch_valid) begin
            r_valid[w_idx][r_way] <= 1'b1;
            r_dirty[w_idx][r_way] <= r_we;
            r_rsp_data            <= w_rsp_word;
         end
      end
   end

   // Tag/data storage carries no reset; validity alone qualifies it.
   always_ff @(posedge i_clk) begin
      if (r_state == ST_LOOKUP && w_hit && r_we)
         r_data[w_idx][w_hit_way][w_off] <= w_merged;
      if (r_state == ST_FETCH_WAIT && i_fetch_valid) begin
         r_tag[w_idx][r_way] <= w_tag;
         for (int k = 0; k < LINE_SIZE; k++)
            r_data[w_idx][r_way][k] <= (r_we && OFF_W'(k) == w_off) ? w_merged : i_fetch_data[k];
      end
   end

endmodule

// File: tb/tb_kv_writeback_cache.sv
// tb_kv_writeback_cache: directed + random stimulus for kv_writeback_cache.
// Expected load/store data come from a flat word memory; expected memory
// traffic comes from a per-set tag/valid/dirty/pointer table.
module tb_kv_writeback_cache;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_req_valid, o_req_ready, i_req_we;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [3:0]  i_req_wstrb;
   logic        o_rsp_valid, i_rsp_ready;
   logic [31:0] o_rsp_data;
   logic [31:0] o_fetch_addr;
   logic        o_fetch_valid, i_fetch_ready, i_fetch_valid, o_fetch_ready;
   logic [31:0] i_fetch_data [4];
   logic [31:0] o_write_data [4];
   logic [31:0] o_write_addr;
   logic        o_write_valid, i_write_ready;

   kv_writeback_cache dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
      .o_fetch_addr(o_fetch_addr), .o_fetch_valid(o_fetch_valid), .i_fetch_ready(i_fetch_ready),
      .i_fetch_data(i_fetch_data), .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
      .o_write_data(o_write_data), .o_write_addr(o_write_addr), .o_write_valid(o_write_valid),
      .i_write_ready(i_write_ready)
   );

   always #5 i_clk = ~i_clk;

   int nvec = 0, nerr = 0;
   int wr_stall = 0, fetch_stall = 0, fetch_dly = 0, rsp_stall = 0;
   bit abort_fw = 1'b0;
   bit got_wb, got_fetch;
   logic [31:0] last_rsp, last_fetch_addr, last_wb_addr, last_wb_w1;

   // Architectural memory (all stores applied) and backing memory contents.
   logic [31:0] gold [logic [31:0]];
   logic [31:0] mem  [logic [31:0]];

   // Cache occupancy table: 16 sets x 4 ways.
   bit          m_valid [16][4];
   bit          m_dirty [16][4];
   int unsigned m_tag   [16][4];
   int unsigned m_rr    [16];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1 + 32'h0123_4567);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : mem_rd(a);
   endfunction

   function automatic logic [127:0] gold_line(input logic [31:0] base);
      return {gold_rd(base + 3), gold_rd(base + 2), gold_rd(base + 1), gold_rd(base)};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 16; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < 4; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      end
      gold.delete();   // unwritten-back dirty data is lost
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, o_req_ready, 1'b1);
      chk({tag, "_valids"}, {o_rsp_valid, o_fetch_valid, o_fetch_ready, o_write_valid}, 4'b0);
      chk({tag, "_addrs"}, {o_fetch_addr, o_write_addr, o_rsp_data}, 96'b0);
      chk({tag, "_wdata"}, {o_write_data[3], o_write_data[2], o_write_data[1], o_write_data[0]}, 128'b0);
   endtask

   task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      int unsigned tg, ix, v;
      bit hit, evict, done, aborted, got_rsp;
      logic [31:0] eaddr, line_a, exp_rsp;
      int lat, wst, fst, fdl, rst;
      tg = a >> 6; ix = (a >> 2) & 15; line_a = a & 32'hFFFF_FFFC;
      hit = 0; v = 0;
      for (int w = 0; w < 4; w++) if (m_valid[ix][w] && m_tag[ix][w] == tg) begin hit = 1; v = w; end
      exp_rsp = gold_rd(a);
      if (we) exp_rsp = merge(exp_rsp, wd, ws);
      evict = 0; eaddr = 0;
      if (!hit) begin
         v = 4;
         for (int w = 3; w >= 0; w--) if (!m_valid[ix][w]) v = w;
         if (v == 4) begin v = m_rr[ix]; m_rr[ix] = (m_rr[ix] + 1) % 4; end
         evict = m_valid[ix][v] && m_dirty[ix][v];
         eaddr = (m_tag[ix][v] << 6) | (ix << 2);
      end
      got_wb = 0; got_fetch = 0; got_rsp = 0; aborted = 0; done = 0;
      wst = wr_stall; fst = fetch_stall; fdl = fetch_dly; rst = rsp_stall;
      i_req_valid = 1; i_req_we = we; i_req_addr = a; i_req_wdata = wd; i_req_wstrb = ws;
      chk("req_ready_idle", o_req_ready, 1'b1);
      @(posedge i_clk); #1;
      i_req_valid = 0; i_req_wdata = $urandom; i_req_addr = $urandom;
      lat = 1;
      while (!done && lat < 400) begin
         i_write_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0; i_rsp_ready = 0;
         if (o_write_valid) begin
            got_wb = 1;
            chk("wb_addr", o_write_addr, eaddr);
            chk("wb_data", {o_write_data[3], o_write_data[2], o_write_data[1], o_write_data[0]}, gold_line(eaddr));
            if (wst == 0) begin
               i_write_ready = 1;
               last_wb_addr = o_write_addr; last_wb_w1 = o_write_data[1];
               for (int k = 0; k < 4; k++) mem[o_write_addr + k] = o_write_data[k];
            end else wst--;
         end
         if (o_fetch_valid) begin
            got_fetch = 1;
            chk("fetch_addr", o_fetch_addr, line_a);
            last_fetch_addr = o_fetch_addr;
            if (fst == 0) i_fetch_ready = 1; else fst--;
         end
         if (o_fetch_ready) begin
            if (abort_fw) begin
               i_rstn = 0; #1;
               chk_reset_outputs("abort");
               aborted = 1; done = 1;
            end else if (fdl == 0) begin
               i_fetch_valid = 1;
               for (int k = 0; k < 4; k++) i_fetch_data[k] = mem_rd(line_a + k);
            end else fdl--;
         end
         if (o_rsp_valid) begin
            if (!got_rsp && hit) chk("hit_latency", lat, 2);
            got_rsp = 1;
            last_rsp = o_rsp_data;
            chk("rsp_data", o_rsp_data, exp_rsp);
            chk("rsp_req_ready", o_req_ready, 1'b0);
            if (rst == 0) begin i_rsp_ready = 1; done = 1; end else rst--;
         end
         @(posedge i_clk); #1;
         lat++;
      end
      i_write_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0; i_rsp_ready = 0;
      chk("no_timeout", done, 1'b1);
      if (aborted) begin
         i_rstn = 1;
         model_reset();
         return;
      end
      chk("wb_seen", got_wb, evict);
      chk("fetch_seen", got_fetch, !hit);
      if (hit) begin
         if (we) m_dirty[ix][v] = 1;
      end else begin
         m_valid[ix][v] = 1; m_tag[ix][v] = tg; m_dirty[ix][v] = we;
      end
      if (we) gold[a] = exp_rsp;
   endtask

   initial begin
      i_rstn = 0; i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_wdata = 0; i_req_wstrb = 0;
      i_rsp_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0; i_write_ready = 0;
      for (int k = 0; k < 4; k++) i_fetch_data[k] = 0;
      mem[32'h104] = 32'hA0; mem[32'h105] = 32'h1111_1111; mem[32'h106] = 32'hA2; mem[32'h107] = 32'hA3;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      chk_reset_outputs("reset");
      i_rstn = 1;
      @(posedge i_clk); #1;

      // Cold miss, then hit in the same line.
      do_req(0, 32'h105, 0, 0);
      chk("p1_fetch_addr", last_fetch_addr, 32'h104);
      chk("p1_no_wb", got_wb, 1'b0);
      chk("p1_rsp", last_rsp, 32'h1111_1111);
      do_req(0, 32'h106, 0, 0);
      chk("p1_hit_rsp", last_rsp, 32'hA2);
      chk("p1_hit_nofetch", got_fetch, 1'b0);

      // Store hit with partial strobe.
      do_req(1, 32'h105, 32'hDEAD_BEEF, 4'b0011);
      chk("p2_store_rsp", last_rsp, 32'h1111_BEEF);
      chk("p2_no_traffic", {got_wb, got_fetch}, 2'b00);
      do_req(0, 32'h105, 0, 0);
      chk("p2_load_back", last_rsp, 32'h1111_BEEF);

      // Fill set 1, then force a dirty eviction under backpressure.
      do_req(0, 32'h144, 0, 0);
      do_req(0, 32'h184, 0, 0);
      do_req(0, 32'h1C4, 0, 0);
      wr_stall = 3; rsp_stall = 3;
      do_req(0, 32'h204, 0, 0);
      wr_stall = 0; rsp_stall = 0;
      chk("p3_wb_addr", last_wb_addr, 32'h104);
      chk("p3_wb_word1", last_wb_w1, 32'h1111_BEEF);
      chk("p3_fetch_addr", last_fetch_addr, 32'h204);
      do_req(0, 32'h105, 0, 0);
      chk("p3_reload_miss", got_fetch, 1'b1);
      chk("p3_reload_data", last_rsp, 32'h1111_BEEF);

      // Clean evictions in set 2: way 0 then way 1 are replaced.
      do_req(0, 32'h008, 0, 0);
      do_req(0, 32'h048, 0, 0);
      do_req(0, 32'h088, 0, 0);
      do_req(0, 32'h0C8, 0, 0);
      do_req(0, 32'h108, 0, 0);
      chk("p5_clean_no_wb", got_wb, 1'b0);
      do_req(0, 32'h148, 0, 0);
      chk("p5_clean_no_wb2", got_wb, 1'b0);
      do_req(0, 32'h088, 0, 0);
      chk("p5_way2_kept", got_fetch, 1'b0);
      do_req(0, 32'h048, 0, 0);
      chk("p5_way1_gone", got_fetch, 1'b1);

      // Reset while waiting for refill data.
      abort_fw = 1;
      do_req(0, 32'h3C5, 0, 0);
      abort_fw = 0;
      do_req(0, 32'h105, 0, 0);
      chk("p6_miss_after_reset", got_fetch, 1'b1);

      // Random traffic over a few sets with random backpressure.
      for (int n = 0; n < 300; n++) begin
         wr_stall = $urandom_range(0, 2); fetch_stall = $urandom_range(0, 2);
         fetch_dly = $urandom_range(0, 2); rsp_stall = $urandom_range(0, 2);
         do_req(1'($urandom_range(0, 1)),
                (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
